// File: rtl/cdb_writeback_arbiter.sv
// Round-robin arbiter that maps up to N_PORT functional-unit writebacks per cycle onto registered CDB ports.
// Optional starvation override is enabled by defining CDB_ARB_STARVE_EN.
module cdb_writeback_arbiter #(
  parameter int N_REQ      = 4,
  parameter int N_PORT     = 2,
  parameter int DATA_W     = 32,
  parameter int PREG_W     = 6,
  parameter int ROB_W      = 3,
  parameter int STARVE_LIM = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic [N_REQ-1:0]         req_valid,
  input  logic [N_REQ*PREG_W-1:0]  req_preg,
  input  logic [N_REQ*DATA_W-1:0]  req_data,
  input  logic [N_REQ*ROB_W-1:0]   req_rob,
  output logic [N_REQ-1:0]         req_ready,
  output logic [N_PORT-1:0]        cdb_valid,
  output logic [N_PORT*PREG_W-1:0] cdb_preg,
  output logic [N_PORT*DATA_W-1:0] cdb_data,
  output logic [N_PORT*ROB_W-1:0]  cdb_rob,
  output logic [N_REQ-1:0]         starved
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic [PTR_W-1:0]  rr_ptr;
  logic [PTR_W-1:0]  rr_ptr_nxt;
  logic [N_REQ-1:0]  grant;
  logic [N_REQ-1:0]  st_grant;
  logic [N_PORT-1:0] port_vld_p0;
  logic [PTR_W-1:0]  port_sel_p0 [N_PORT];

  logic [PREG_W-1:0] preg_arr [N_REQ];
  logic [DATA_W-1:0] data_arr [N_REQ];
  logic [ROB_W-1:0]  rob_arr  [N_REQ];

  always_comb begin
    for (int i = 0; i < N_REQ; i++) begin
      preg_arr[i] = req_preg[i*PREG_W +: PREG_W];
      data_arr[i] = req_data[i*DATA_W +: DATA_W];
      rob_arr[i]  = req_rob[i*ROB_W +: ROB_W];
    end
  end

  // Stage p0: starved requesters claim the lowest ports, round-robin fills the rest.
  always_comb begin
    int n;
    int t;
    logic [PTR_W-1:0] idx;
    n           = 0;
    t           = 0;
    idx         = '0;
    grant       = '0;
    st_grant    = '0;
    rr_ptr_nxt  = rr_ptr;
    port_vld_p0 = '0;
    for (int k = 0; k < N_PORT; k++) port_sel_p0[k] = '0;
`ifdef CDB_ARB_STARVE_EN
    for (int i = 0; i < N_REQ; i++) begin
      if (!flush && req_valid[i] && starved[i] && n < N_PORT) begin
        st_grant[i] = 1'b1;
        for (int k = 0; k < N_PORT; k++) begin
          if (k == n) begin
            port_vld_p0[k] = 1'b1;
            port_sel_p0[k] = PTR_W'(i);
          end
        end
        n = n + 1;
      end
    end
`endif
    grant = st_grant;
    for (int s = 0; s < N_REQ; s++) begin
      t = int'(rr_ptr) + s;
      if (t >= N_REQ) t = t - N_REQ;
      idx = PTR_W'(t);
      if (!flush && req_valid[idx] && !grant[idx] && n < N_PORT) begin
        grant[idx] = 1'b1;
        for (int k = 0; k < N_PORT; k++) begin
          if (k == n) begin
            port_vld_p0[k] = 1'b1;
            port_sel_p0[k] = idx;
          end
        end
        rr_ptr_nxt = (t + 1 == N_REQ) ? '0 : PTR_W'(t + 1);
        n = n + 1;
      end
    end
  end

  assign req_ready = grant & {N_REQ{rst}};

  // Stage p1: registered CDB; idle ports keep their last payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr    <= '0;
      cdb_valid <= '0;
      cdb_preg  <= '0;
      cdb_data  <= '0;
      cdb_rob   <= '0;
    end else begin
      rr_ptr    <= rr_ptr_nxt;
      cdb_valid <= port_vld_p0;
      for (int k = 0; k < N_PORT; k++) begin
        if (port_vld_p0[k]) begin
          cdb_preg[k*PREG_W +: PREG_W] <= preg_arr[port_sel_p0[k]];
          cdb_data[k*DATA_W +: DATA_W] <= data_arr[port_sel_p0[k]];
          cdb_rob[k*ROB_W +: ROB_W]    <= rob_arr[port_sel_p0[k]];
        end
      end
    end
  end

`ifdef CDB_ARB_STARVE_EN
  localparam int CNT_W = $clog2(STARVE_LIM + 1);
  logic [CNT_W-1:0] starve_cnt [N_REQ];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_REQ; i++) starve_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (flush || !req_valid[i] || grant[i]) starve_cnt[i] <= '0;
        else if (starve_cnt[i] != CNT_W'(STARVE_LIM)) starve_cnt[i] <= starve_cnt[i] + 1'b1;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_REQ; i++) starved[i] = (starve_cnt[i] == CNT_W'(STARVE_LIM));
  end
`else
  assign starved = '0;
`endif

endmodule

// File: tb/tb_cdb_writeback_arbiter.sv
// Scoreboard bench for cdb_writeback_arbiter (default round-robin build, N_REQ=4, N_PORT=2).
module tb_cdb_writeback_arbiter;
  localparam int NR = 4;
  localparam int NP = 2;
  localparam int DW = 32;
  localparam int PW = 6;
  localparam int RW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic flush = 1'b0;
  logic [NR-1:0]    req_valid = '0;
  logic [NR*PW-1:0] req_preg;
  logic [NR*DW-1:0] req_data;
  logic [NR*RW-1:0] req_rob;
  logic [NR-1:0]    req_ready;
  logic [NP-1:0]    cdb_valid;
  logic [NP*PW-1:0] cdb_preg;
  logic [NP*DW-1:0] cdb_data;
  logic [NP*RW-1:0] cdb_rob;
  logic [NR-1:0]    starved;

  logic [PW-1:0] preg_a [NR];
  logic [DW-1:0] data_a [NR];
  logic [RW-1:0] rob_a  [NR];

  typedef struct packed {
    logic [NP-1:0]         v;
    logic [NP-1:0][PW-1:0] preg;
    logic [NP-1:0][DW-1:0] data;
    logic [NP-1:0][RW-1:0] rob;
  } exp_t;

  exp_t sb[$];
  int total = 0;
  int bad = 0;
  int m_ptr = 0;
  logic [NR-1:0] last_g = '0;

  always #5 clk = ~clk;

  always_comb begin
    for (int i = 0; i < NR; i++) begin
      req_preg[i*PW +: PW] = preg_a[i];
      req_data[i*DW +: DW] = data_a[i];
      req_rob[i*RW +: RW]  = rob_a[i];
    end
  end

  cdb_writeback_arbiter #(
    .N_REQ(NR), .N_PORT(NP), .DATA_W(DW), .PREG_W(PW), .ROB_W(RW), .STARVE_LIM(8)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .req_valid(req_valid), .req_preg(req_preg), .req_data(req_data), .req_rob(req_rob),
    .req_ready(req_ready),
    .cdb_valid(cdb_valid), .cdb_preg(cdb_preg), .cdb_data(cdb_data), .cdb_rob(cdb_rob),
    .starved(starved)
  );

  task automatic set_req(input int i, input logic v, input logic [PW-1:0] p,
                         input logic [DW-1:0] d, input logic [RW-1:0] r);
    req_valid[i] = v;
    preg_a[i] = p;
    data_a[i] = d;
    rob_a[i] = r;
  endtask

  // One arbitration cycle: model the grant, push the expected CDB beat, pop and compare after the edge.
  task automatic step(input logic fl, input logic use_want, input logic [NR-1:0] want);
    exp_t e;
    logic [NR-1:0] eg;
    int nw;
    int i;
    int last;
    flush = fl;
    #1;
    e = '0;
    eg = '0;
    nw = 0;
    last = -1;
    if (!fl) begin
      for (int s = 0; s < NR; s++) begin
        i = (m_ptr + s) % NR;
        if (req_valid[i] && nw < NP) begin
          eg[i] = 1'b1;
          e.v[nw] = 1'b1;
          e.preg[nw] = preg_a[i];
          e.data[nw] = data_a[i];
          e.rob[nw] = rob_a[i];
          nw = nw + 1;
          last = i;
        end
      end
    end
    total++;
    if (req_ready !== eg) begin
      bad++;
      $display("FAIL req_ready_model: got %b want %b", req_ready, eg);
    end
    if (use_want) begin
      total++;
      if (req_ready !== want) begin
        bad++;
        $display("FAIL req_ready_table: got %b want %b", req_ready, want);
      end
    end
    sb.push_back(e);
    if (last >= 0) m_ptr = (last + 1) % NR;
    last_g = eg;
    @(posedge clk);
    #1;
    flush = 1'b0;
    e = sb.pop_front();
    total++;
    if (cdb_valid !== e.v) begin
      bad++;
      $display("FAIL cdb_valid: got %b want %b", cdb_valid, e.v);
    end
    for (int k = 0; k < NP; k++) begin
      if (e.v[k]) begin
        total++;
        if ({cdb_preg[k*PW +: PW], cdb_data[k*DW +: DW], cdb_rob[k*RW +: RW]} !==
            {e.preg[k], e.data[k], e.rob[k]}) begin
          bad++;
          $display("FAIL cdb_port%0d: got preg=%0d data=%h rob=%0d want preg=%0d data=%h rob=%0d",
                   k, cdb_preg[k*PW +: PW], cdb_data[k*DW +: DW], cdb_rob[k*RW +: RW],
                   e.preg[k], e.data[k], e.rob[k]);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    flush = 1'b0;
    req_valid = '0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    m_ptr = 0;
    sb.delete();
  endtask

  task automatic test_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, PW'(i + 1), 32'hA000_0000 + DW'(i), RW'(i));
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (req_ready !== 4'b0000) begin
      bad++;
      $display("FAIL reset_ready: got %b want 0000", req_ready);
    end
    total++;
    if (cdb_valid !== 2'b00) begin
      bad++;
      $display("FAIL reset_cdb_valid: got %b want 00", cdb_valid);
    end
    total++;
    if (cdb_data !== '0 || cdb_preg !== '0 || cdb_rob !== '0) begin
      bad++;
      $display("FAIL reset_cdb_payload: got data=%h preg=%h rob=%h want 0", cdb_data, cdb_preg, cdb_rob);
    end
    rst = 1'b1;
    m_ptr = 0;
    step(1'b0, 1'b1, 4'b0011);
  endtask

  task automatic test_full_load();
    logic [NR-1:0] tbl [4];
    tbl[0] = 4'b0011;
    tbl[1] = 4'b1100;
    tbl[2] = 4'b0011;
    tbl[3] = 4'b1100;
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, PW'(10 + i), 32'hB000_0000 + DW'(i), RW'(i));
    for (int c = 0; c < 4; c++) begin
      step(1'b0, 1'b1, tbl[c]);
      for (int i = 0; i < NR; i++)
        if (last_g[i]) set_req(i, 1'b1, PW'(20 + 4 * c + i), 32'hC000_0000 + DW'(16 * c + i), RW'(c + i));
    end
  endtask

  task automatic test_single();
    do_reset();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0, '0);
    set_req(2, 1'b1, 6'd17, 32'hDEADBEEF, 3'd5);
    step(1'b0, 1'b1, 4'b0100);
    total++;
    if (cdb_valid !== 2'b01 || cdb_preg[PW-1:0] !== 6'd17 || cdb_data[DW-1:0] !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL single_port0: got v=%b preg=%0d data=%h want v=01 preg=17 data=deadbeef",
               cdb_valid, cdb_preg[PW-1:0], cdb_data[DW-1:0]);
    end
    set_req(2, 1'b0, '0, '0, '0);
  endtask

  task automatic test_wrap();
    set_req(3, 1'b1, 6'd33, 32'h3333_3333, 3'd3);
    set_req(0, 1'b1, 6'd40, 32'h0000_0040, 3'd0);
    step(1'b0, 1'b1, 4'b1001);
    total++;
    if (cdb_preg[PW-1:0] !== 6'd33 || cdb_preg[2*PW-1:PW] !== 6'd40) begin
      bad++;
      $display("FAIL wrap_order: got port0=%0d port1=%0d want port0=33 port1=40",
               cdb_preg[PW-1:0], cdb_preg[2*PW-1:PW]);
    end
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, PW'(50 + i), 32'hD000_0000 + DW'(i), RW'(i));
    step(1'b0, 1'b1, 4'b0110);
  endtask

  task automatic test_idle();
    req_valid = '0;
    step(1'b0, 1'b1, 4'b0000);
  endtask

  task automatic test_flush();
    for (int i = 0; i < NR; i++) set_req(i, 1'b1, PW'(60 + i), 32'hE000_0000 + DW'(i), RW'(i));
    step(1'b1, 1'b1, 4'b0000);
    step(1'b0, 1'b1, 4'b1001);
  endtask

  task automatic test_back_to_back();
    logic fl;
    for (int c = 0; c < 60; c++) begin
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] || last_g[i])
          set_req(i, ($urandom_range(0, 3) != 0), PW'($urandom), DW'($urandom), RW'($urandom));
      end
      fl = ($urandom_range(0, 15) == 0);
      step(fl, 1'b0, 4'b0000);
    end
  endtask

  initial begin
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, '0, '0, '0);
    test_reset();
    test_full_load();
    test_single();
    test_wrap();
    test_idle();
    test_flush();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
